// File: rtl/ov2640_pkg.sv
// Shared constants, types and helpers for the OV2640 YUV422 -> RGB565 converter.
// Colour math is BT.601 in Q8 fixed point: each coefficient is the real
// coefficient times 256, and products are floor-shifted back by 8 bits.
package ov2640_pkg;

  // BT.601 Q8 coefficients
  localparam int COEF_RV = 359;  // V contribution to R (1.402)
  localparam int COEF_GU = 88;   // U contribution to G (0.344)
  localparam int COEF_GV = 183;  // V contribution to G (0.714)
  localparam int COEF_BU = 454;  // U contribution to B (1.772)
  localparam int Q_SHIFT = 8;

  // Chroma is stored offset-binary around this value
  localparam int CHROMA_OFS = 128;

  // RGB565 field widths
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  // Internal arithmetic widths
  localparam int DELTA_W = 9;    // signed chroma delta, -128..127
  localparam int PROD_W  = 19;   // signed coefficient products
  localparam int COMP_W  = 11;   // signed per-component sums before clamping

  // Pair FSM: waiting for a U word, or holding a U word and waiting for its V
  typedef enum logic {
    WAIT_U = 1'b0,
    HAVE_U = 1'b1
  } pair_state_e;

  typedef logic signed [COMP_W-1:0] comp_t;

  // Stage-1 result: both lumas of the pair plus the shared chroma terms
  typedef struct packed {
    logic [7:0] y0;
    logic [7:0] y1;
    comp_t      cr;
    comp_t      cg;
    comp_t      cb;
  } s1_t;

  // Remove the offset-binary bias from a chroma byte
  function automatic logic signed [DELTA_W-1:0] chroma_delta(input logic [7:0] c);
    return $signed({1'b0, c}) - $signed(DELTA_W'(CHROMA_OFS));
  endfunction

  // Saturate a signed component sum into 0..255
  function automatic logic [7:0] clamp8(input comp_t v);
    if (v < 0) begin
      return 8'h00;
    end
    if (v > comp_t'(255)) begin
      return 8'hFF;
    end
    return v[7:0];
  endfunction

endpackage

// File: rtl/yuv_pix_to_rgb565.sv
// Converts one pixel (luma plus precomputed chroma terms) to RGB565.
// Purely combinational; the top time-shares a single instance for both
// pixels of a pair. GRAY ignores the chroma terms and replicates the luma.
module yuv_pix_to_rgb565
  import ov2640_pkg::*;
#(
  parameter bit GRAY = 1'b0
) (
  input  logic [7:0]       y_i,
  input  comp_t            cr_i,
  input  comp_t            cg_i,
  input  comp_t            cb_i,
  output logic [RGB_W-1:0] rgb_o
);

  comp_t      y_s;
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;

  assign y_s = comp_t'({3'b000, y_i});

  // Add the chroma terms to the luma, saturate each channel and pack
  always_comb begin
    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    r8 = clamp8(y_s + cr_i);
    g8 = clamp8(y_s - cg_i);
    b8 = clamp8(y_s + cb_i);
    if (GRAY) begin
      r8 = y_i;
      g8 = y_i;
      b8 = y_i;
    end
    rgb_o = {r8[7 -: R_W], g8[7 -: G_W], b8[7 -: B_W]};
  end

endmodule

// File: rtl/ov2640_yuv_to_rgb565.sv
// OV2640 YUV422 -> RGB565 converter.
// Pairs each U word with the following V word, computes the BT.601 chroma
// terms once per pair (stage 1), then emits pixel 0 and pixel 1 on two
// consecutive cycles (stage 2). VSYNC low clears everything once per frame.
module ov2640_yuv_to_rgb565
  import ov2640_pkg::*;
#(
  parameter bit SWAP_UV = 1'b0,
  parameter bit GRAY    = 1'b0
) (
  input  logic              PCLK,
  input  logic              VSYNC,
  input  logic              valid_in,
  input  logic              u_chroma_in,
  input  logic [15:0]       pixel_in,
  output logic              rgb_valid,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              sof_out,
  output logic              orphan_err
);

  // ---------------------------------------------------------------------------
  // Pair FSM
  // ---------------------------------------------------------------------------
  pair_state_e state_q, state_d;
  logic        is_u;
  logic        take_u;      // latch Y0/U from pixel_in
  logic        take_v;      // latch Y1/V from pixel_in and launch stage 1
  logic        orphan_set;  // current word breaks U/V pairing

  // A sensor programmed for YVYU flips the meaning of the chroma flag
  assign is_u = u_chroma_in ^ SWAP_UV;

  // State register
  always_ff @(posedge PCLK or negedge VSYNC) begin
    if (!VSYNC) begin
      state_q <= WAIT_U;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_U: if (valid_in && is_u)  state_d = HAVE_U;
      HAVE_U: if (valid_in && !is_u) state_d = WAIT_U;
      default: state_d = WAIT_U;
    endcase
  end

  // FSM outputs: which half of the pair to capture and whether a word is orphaned
  always_comb begin
    take_u     = 1'b0;
    take_v     = 1'b0;
    orphan_set = 1'b0;
    unique case (state_q)
      WAIT_U: begin
        take_u     = valid_in && is_u;
        orphan_set = valid_in && !is_u;
      end
      HAVE_U: begin
        take_v     = valid_in && !is_u;
        // A second U overwrites the first; the earlier pixel is lost
        take_u     = valid_in && is_u;
        orphan_set = valid_in && is_u;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pair capture registers
  // ---------------------------------------------------------------------------
  logic [7:0] y0_q, u_q, y1_q, v_q;
  logic       pair_vld_q;
  logic       orphan_q;

  // Capture the two words of a pair and flag a completed pair for stage 1
  always_ff @(posedge PCLK or negedge VSYNC) begin
    if (!VSYNC) begin
      // NOTE: data registers are reset too so nothing from a previous frame can leak out after VSYNC.
      y0_q       <= '0;
      u_q        <= '0;
      y1_q       <= '0;
      v_q        <= '0;
      pair_vld_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      if (take_u) begin
        y0_q <= pixel_in[15:8];
        u_q  <= pixel_in[7:0];
      end
      if (take_v) begin
        y1_q <= pixel_in[15:8];
        v_q  <= pixel_in[7:0];
      end
      pair_vld_q <= take_v;
      if (orphan_set) begin
        orphan_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: chroma terms shared by both pixels of the pair
  // ---------------------------------------------------------------------------
  logic signed [DELTA_W-1:0] du, dv;
  logic signed [PROD_W-1:0]  du_x, dv_x;
  logic signed [PROD_W-1:0]  p_r, p_g, p_b;
  s1_t                       s1_d, s1_q;
  logic                      s1_vld_q;

  // Signed Q8 products, floor-shifted back to integer chroma terms
  always_comb begin
    du   = chroma_delta(u_q);
    dv   = chroma_delta(v_q);
    du_x = {{(PROD_W-DELTA_W){du[DELTA_W-1]}}, du};
    dv_x = {{(PROD_W-DELTA_W){dv[DELTA_W-1]}}, dv};
    p_r  = dv_x * $signed(PROD_W'(COEF_RV));
    p_g  = du_x * $signed(PROD_W'(COEF_GU)) + dv_x * $signed(PROD_W'(COEF_GV));
    p_b  = du_x * $signed(PROD_W'(COEF_BU));
    s1_d.y0 = y0_q;
    s1_d.y1 = y1_q;
    s1_d.cr = comp_t'(p_r >>> Q_SHIFT);
    s1_d.cg = comp_t'(p_g >>> Q_SHIFT);
    s1_d.cb = comp_t'(p_b >>> Q_SHIFT);
  end

  // Stage-1 register: single entry, refilled only when a pair completes
  always_ff @(posedge PCLK or negedge VSYNC) begin
    if (!VSYNC) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      if (pair_vld_q) begin
        s1_q <= s1_d;
      end
      s1_vld_q <= pair_vld_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: serialise pixel 0 then pixel 1 through one converter
  // ---------------------------------------------------------------------------
  logic             pend1_q;    // pixel 1 of the current stage-1 entry is due
  logic             first_q;    // no pixel emitted yet since reset
  logic             emit;
  logic [7:0]       pix_y;
  logic [RGB_W-1:0] pix_rgb;
  logic             rgb_valid_q;
  logic [RGB_W-1:0] rgb_q;
  logic             sof_q;

  assign emit  = s1_vld_q || pend1_q;
  assign pix_y = pend1_q ? s1_q.y1 : s1_q.y0;

  yuv_pix_to_rgb565 #(
    .GRAY (GRAY)
  ) u_pix (
    .y_i   (pix_y),
    .cr_i  (s1_q.cr),
    .cg_i  (s1_q.cg),
    .cb_i  (s1_q.cb),
    .rgb_o (pix_rgb)
  );

  // Output register: one strobe per pixel, start-of-frame on the very first
  always_ff @(posedge PCLK or negedge VSYNC) begin
    if (!VSYNC) begin
      pend1_q     <= 1'b0;
      first_q     <= 1'b1;
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
      sof_q       <= 1'b0;
    end else begin
      pend1_q     <= s1_vld_q && !pend1_q;
      rgb_valid_q <= emit;
      sof_q       <= s1_vld_q && !pend1_q && first_q;
      if (emit) begin
        rgb_q <= pix_rgb;
      end
      if (s1_vld_q && !pend1_q) begin
        first_q <= 1'b0;
      end
    end
  end

  assign rgb_valid  = rgb_valid_q;
  assign rgb_out    = rgb_q;
  assign sof_out    = sof_q;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_ov2640_yuv_to_rgb565.sv
// Directed bench for ov2640_yuv_to_rgb565. Three instances share the input
// stimulus: default build, GRAY=1 build and SWAP_UV=1 build.
module tb_ov2640_yuv_to_rgb565;

  logic        PCLK = 1'b0;
  logic        VSYNC = 1'b0;
  logic        valid_in = 1'b0;
  logic        u_chroma_in = 1'b0;
  logic [15:0] pixel_in = '0;

  logic        rv_m, sof_m, oe_m;
  logic [15:0] ro_m;
  logic        rv_g, sof_g, oe_g;
  logic [15:0] ro_g;
  logic        rv_s, sof_s, oe_s;
  logic [15:0] ro_s;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  ov2640_yuv_to_rgb565 #(.SWAP_UV(1'b0), .GRAY(1'b0)) dut (
    .PCLK(PCLK), .VSYNC(VSYNC), .valid_in(valid_in), .u_chroma_in(u_chroma_in),
    .pixel_in(pixel_in), .rgb_valid(rv_m), .rgb_out(ro_m), .sof_out(sof_m),
    .orphan_err(oe_m));

  ov2640_yuv_to_rgb565 #(.SWAP_UV(1'b0), .GRAY(1'b1)) dut_gray (
    .PCLK(PCLK), .VSYNC(VSYNC), .valid_in(valid_in), .u_chroma_in(u_chroma_in),
    .pixel_in(pixel_in), .rgb_valid(rv_g), .rgb_out(ro_g), .sof_out(sof_g),
    .orphan_err(oe_g));

  ov2640_yuv_to_rgb565 #(.SWAP_UV(1'b1), .GRAY(1'b0)) dut_swap (
    .PCLK(PCLK), .VSYNC(VSYNC), .valid_in(valid_in), .u_chroma_in(u_chroma_in),
    .pixel_in(pixel_in), .rgb_valid(rv_s), .rgb_out(ro_s), .sof_out(sof_s),
    .orphan_err(oe_s));

  // Present one word for one cycle; called and returns at a falling edge
  task automatic put(input logic isu, input logic [7:0] y, input logic [7:0] c);
    valid_in    = 1'b1;
    u_chroma_in = isu;
    pixel_in    = {y, c};
    @(negedge PCLK);
    valid_in    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (rv_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rv_m); end
    checks++; if (ro_m !== 16'h0000) begin errors++; $display("FAIL reset_rgb got %h exp 0000", ro_m); end
    checks++; if (sof_m !== 1'b0) begin errors++; $display("FAIL reset_sof got %b exp 0", sof_m); end
    checks++; if (oe_m !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", oe_m); end
    checks++; if (rv_g !== 1'b0 || rv_s !== 1'b0) begin errors++; $display("FAIL reset_valid_variants got %b%b exp 00", rv_g, rv_s); end
    VSYNC = 1'b1;
    @(negedge PCLK);
  endtask

  // Neutral gray pair; first pair after reset, so pixel 0 carries sof
  task automatic test_neutral();
    logic exp_v;
    put(1'b1, 8'h80, 8'h80);
    put(1'b0, 8'h80, 8'h80);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      exp_v = (k == 2) || (k == 3);
      checks++; if (rv_m !== exp_v) begin errors++; $display("FAIL neutral_valid c%0d got %b exp %b", k, rv_m, exp_v); end
      if (exp_v) begin
        checks++; if (ro_m !== 16'h8410) begin errors++; $display("FAIL neutral_rgb c%0d got %h exp 8410", k, ro_m); end
        checks++; if (sof_m !== (k == 2)) begin errors++; $display("FAIL neutral_sof c%0d got %b exp %b", k, sof_m, k == 2); end
        checks++; if (ro_g !== 16'h8410) begin errors++; $display("FAIL neutral_gray_rgb c%0d got %h exp 8410", k, ro_g); end
      end
    end
  endtask

  // Saturated red: B underflows to -1 and clamps to 0
  task automatic test_red();
    logic exp_v;
    put(1'b1, 8'd76, 8'd85);
    put(1'b0, 8'd76, 8'd255);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      exp_v = (k == 2) || (k == 3);
      checks++; if (rv_m !== exp_v) begin errors++; $display("FAIL red_valid c%0d got %b exp %b", k, rv_m, exp_v); end
      if (exp_v) begin
        checks++; if (ro_m !== 16'hF800) begin errors++; $display("FAIL red_rgb c%0d got %h exp f800", k, ro_m); end
        checks++; if (sof_m !== 1'b0) begin errors++; $display("FAIL red_sof c%0d got %b exp 0", k, sof_m); end
        checks++; if (ro_g !== 16'h4A69) begin errors++; $display("FAIL red_gray_rgb c%0d got %h exp 4a69", k, ro_g); end
      end
    end
  endtask

  // R overflows past 255; G = 255 - 90 = 165
  task automatic test_clamp_high();
    logic exp_v;
    put(1'b1, 8'd255, 8'h80);
    put(1'b0, 8'd255, 8'd255);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      exp_v = (k == 2) || (k == 3);
      checks++; if (rv_m !== exp_v) begin errors++; $display("FAIL clamp_valid c%0d got %b exp %b", k, rv_m, exp_v); end
      if (exp_v) begin
        checks++; if (ro_m !== 16'hFD3F) begin errors++; $display("FAIL clamp_rgb c%0d got %h exp fd3f", k, ro_m); end
        checks++; if (ro_g !== 16'hFFFF) begin errors++; $display("FAIL clamp_gray_rgb c%0d got %h exp ffff", k, ro_g); end
      end
    end
  endtask

  // V first (orphan), then U, U (overwrite), V: only the second U's pixel survives
  task automatic test_orphan();
    int n;
    checks++; if (oe_m !== 1'b0) begin errors++; $display("FAIL orphan_before got %b exp 0", oe_m); end
    put(1'b0, 8'h11, 8'h80);
    checks++; if (oe_m !== 1'b1) begin errors++; $display("FAIL orphan_v_first got %b exp 1", oe_m); end
    put(1'b1, 8'h20, 8'h80);
    put(1'b1, 8'h40, 8'h80);
    put(1'b0, 8'h60, 8'h80);
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge PCLK);
      if (rv_m === 1'b1) begin
        if (n == 0) begin
          checks++; if (ro_m !== 16'h4208 || k != 2) begin errors++; $display("FAIL orphan_pix0 c%0d got %h exp 4208 at c2", k, ro_m); end
        end else begin
          checks++; if (ro_m !== 16'h630C || k != 3) begin errors++; $display("FAIL orphan_pix1 c%0d got %h exp 630c at c3", k, ro_m); end
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL orphan_count got %0d exp 2", n); end
    checks++; if (oe_m !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", oe_m); end
  endtask

  // Inverted chroma flag: only the SWAP_UV build forms a pair
  task automatic test_swap();
    logic exp_v;
    put(1'b0, 8'd76, 8'd85);
    put(1'b1, 8'd76, 8'd255);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      exp_v = (k == 2) || (k == 3);
      checks++; if (rv_s !== exp_v) begin errors++; $display("FAIL swap_valid c%0d got %b exp %b", k, rv_s, exp_v); end
      checks++; if (rv_m !== 1'b0) begin errors++; $display("FAIL swap_main_valid c%0d got %b exp 0", k, rv_m); end
      if (exp_v) begin
        checks++; if (ro_s !== 16'hF800) begin errors++; $display("FAIL swap_rgb c%0d got %h exp f800", k, ro_s); end
      end
    end
  endtask

  // Strong chroma: colour build saturates, GRAY build replicates luma
  task automatic test_gray();
    logic [15:0] exp_m, exp_g;
    put(1'b1, 8'hF0, 8'h00);
    put(1'b0, 8'h10, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      checks++; if (rv_g !== ((k == 2) || (k == 3))) begin errors++; $display("FAIL gray_valid c%0d got %b", k, rv_g); end
      if ((k == 2) || (k == 3)) begin
        exp_m = (k == 2) ? 16'hFE01 : 16'hC000;
        exp_g = (k == 2) ? 16'hF79E : 16'h1082;
        checks++; if (ro_g !== exp_g) begin errors++; $display("FAIL gray_rgb c%0d got %h exp %h", k, ro_g, exp_g); end
        checks++; if (ro_m !== exp_m) begin errors++; $display("FAIL gray_color_rgb c%0d got %h exp %h", k, ro_m, exp_m); end
      end
    end
  endtask

  // Pairs at the maximum legal rate: second V arrives at T+2
  task automatic test_back_to_back();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h8410;
    exp_seq[1] = 16'h1082;
    exp_seq[2] = 16'hF79E;
    exp_seq[3] = 16'h4208;
    put(1'b1, 8'h80, 8'h80);
    put(1'b0, 8'h10, 8'h80);
    put(1'b1, 8'hF0, 8'h80);
    put(1'b0, 8'h40, 8'h80);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge PCLK);
      checks++; if (rv_m !== (k < 4)) begin errors++; $display("FAIL b2b_valid c%0d got %b exp %b", k, rv_m, k < 4); end
      if (k < 4) begin
        checks++; if (ro_m !== exp_seq[k]) begin errors++; $display("FAIL b2b_rgb c%0d got %h exp %h", k, ro_m, exp_seq[k]); end
      end
    end
  endtask

  // VSYNC drops while pixel 0 is on the output; pixel 1 must never appear
  task automatic test_reset_mid();
    logic exp_v;
    VSYNC = 1'b0;
    @(negedge PCLK);
    VSYNC = 1'b1;
    @(negedge PCLK);
    checks++; if (oe_m !== 1'b0) begin errors++; $display("FAIL mid_orphan_cleared got %b exp 0", oe_m); end
    put(1'b1, 8'h80, 8'h80);
    put(1'b0, 8'h80, 8'h80);
    @(negedge PCLK);
    @(posedge PCLK);
    #2;
    checks++; if (rv_m !== 1'b1 || sof_m !== 1'b1) begin errors++; $display("FAIL mid_pix0 got v%b s%b exp v1 s1", rv_m, sof_m); end
    VSYNC = 1'b0;
    #1;
    checks++; if (rv_m !== 1'b0 || ro_m !== 16'h0000 || sof_m !== 1'b0) begin errors++; $display("FAIL mid_async_clear got v%b rgb %h s%b exp v0 0000 s0", rv_m, ro_m, sof_m); end
    @(negedge PCLK);
    @(negedge PCLK);
    VSYNC = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge PCLK);
      checks++; if (rv_m !== 1'b0) begin errors++; $display("FAIL mid_no_pix1 c%0d got %b exp 0", k, rv_m); end
    end
    put(1'b1, 8'h10, 8'h80);
    put(1'b0, 8'hF0, 8'h80);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      exp_v = (k == 2) || (k == 3);
      checks++; if (rv_m !== exp_v) begin errors++; $display("FAIL mid_after_valid c%0d got %b exp %b", k, rv_m, exp_v); end
      if (exp_v) begin
        checks++; if (sof_m !== (k == 2)) begin errors++; $display("FAIL mid_after_sof c%0d got %b exp %b", k, sof_m, k == 2); end
        checks++; if (ro_m !== ((k == 2) ? 16'h1082 : 16'hF79E)) begin errors++; $display("FAIL mid_after_rgb c%0d got %h", k, ro_m); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_neutral();
    test_red();
    test_clamp_high();
    test_orphan();
    test_swap();
    test_gray();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
